// File: rtl/odu_chid_scheduler_pkg.sv
// Shared sizing constants, FSM encoding and pointer helper for the ODU channel scheduler.
// Imported by the rotating priority encoder and by the scheduler top.
package odu_chid_scheduler_pkg;

    localparam int NUM_CH    = 80;
    localparam int CHID_W    = 7;
    localparam int BURST_LEN = 4;
    localparam int RCNT_W    = 16;
    localparam int BCNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    // Round-robin successor of a channel id, wrapping NUM_CH-1 back to 0.
    function automatic logic [CHID_W-1:0] next_ptr(input logic [CHID_W-1:0] chid);
        return (chid == CHID_W'(NUM_CH - 1)) ? '0 : chid + CHID_W'(1);
    endfunction

endpackage

// File: rtl/odu_chid_scheduler_rr_find.sv
// Rotating priority encoder: first set bit of eligible at or above ptr, wrapping to 0.
// Purely combinational; found=0 when no channel is eligible.
module odu_chid_scheduler_rr_find
    import odu_chid_scheduler_pkg::*;
(
    input  logic [NUM_CH-1:0] eligible,
    input  logic [CHID_W-1:0] ptr,
    output logic              found,
    output logic [CHID_W-1:0] index
);

    logic [CHID_W:0] sum;

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        found = 1'b0;
        index = '0;
        sum   = '0;
        // Scan farthest offset first so the nearest eligible channel overwrites the result.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (CHID_W + 1)'(i);
            if (sum >= (CHID_W + 1)'(NUM_CH)) begin
                sum = sum - (CHID_W + 1)'(NUM_CH);
            end
            if (eligible[sum[CHID_W-1:0]]) begin
                found = 1'b1;
                index = sum[CHID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/odu_chid_scheduler.sv
// Round-robin scheduler sharing one ODU frame generator across NUM_CH channels,
// issuing BURST_LEN requests per grant and masking channels that report errors.
module odu_chid_scheduler
    import odu_chid_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] enable_chid,
    input  logic [NUM_CH-1:0] type_chid,
    input  logic [NUM_CH-1:0] i_error_chid,
    output logic              gen_valid,
    output logic [CHID_W-1:0] gen_chid,
    output logic              gen_type,
    input  logic              gen_ready,
    output logic              busy,
    output logic [NUM_CH-1:0] err_mask,
    output logic [RCNT_W-1:0] round_cnt
);

    state_t            state;
    logic [CHID_W-1:0] ptr;
    logic [CHID_W-1:0] last_grant;
    logic              last_valid;
    logic [BCNT_W-1:0] burst_cnt;
    logic              start_d;

    logic [NUM_CH-1:0] eligible;
    logic              found;
    logic [CHID_W-1:0] grant;
    logic              handshake;
    logic              end_grant;
    logic              wrapped;

    assign eligible  = enable_chid & ~err_mask;
    assign handshake = gen_valid & gen_ready;
    assign end_grant = handshake &&
                       ((burst_cnt == BCNT_W'(BURST_LEN - 1)) || err_mask[gen_chid] || !start);
    // A grant at or below the previous one means the pointer went all the way round.
    assign wrapped   = last_valid && (grant <= last_grant);

    odu_chid_scheduler_rr_find u_rr_find (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (found),
        .index    (grant)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            start_d  <= 1'b0;
            err_mask <= '0;
        end else begin
            start_d  <= start;
            err_mask <= ((start && !start_d) ? '0 : err_mask) | i_error_chid;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            last_grant <= '0;
            last_valid <= 1'b0;
            burst_cnt  <= '0;
            gen_valid  <= 1'b0;
            gen_chid   <= '0;
            gen_type   <= 1'b0;
            busy       <= 1'b0;
            round_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    last_valid <= 1'b0;
                    if (start) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!start) begin
                        state <= ST_IDLE;
                    end else if (found) begin
                        gen_chid   <= grant;
                        gen_type   <= type_chid[grant];
                        burst_cnt  <= '0;
                        gen_valid  <= 1'b1;
                        busy       <= 1'b1;
                        last_grant <= grant;
                        last_valid <= 1'b1;
                        state      <= ST_ISSUE;
                        if (wrapped && (round_cnt != '1)) begin
                            round_cnt <= round_cnt + RCNT_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    // The request is only withdrawn after it has been accepted.
                    if (end_grant) begin
                        gen_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= next_ptr(gen_chid);
                        state     <= start ? ST_ARB : ST_IDLE;
                    end else if (handshake) begin
                        burst_cnt <= burst_cnt + BCNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odu_chid_scheduler.sv
// Directed bench for odu_chid_scheduler: expected frames go into a scoreboard queue,
// and a negedge monitor pops and compares on every generator handshake.
module tb_odu_chid_scheduler;
    import odu_chid_scheduler_pkg::*;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic [NUM_CH-1:0] enable_chid;
    logic [NUM_CH-1:0] type_chid;
    logic [NUM_CH-1:0] i_error_chid;
    logic              gen_valid;
    logic [CHID_W-1:0] gen_chid;
    logic              gen_type;
    logic              gen_ready;
    logic              busy;
    logic [NUM_CH-1:0] err_mask;
    logic [RCNT_W-1:0] round_cnt;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    logic [CHID_W:0] exp_q[$];

    odu_chid_scheduler dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .enable_chid  (enable_chid),
        .type_chid    (type_chid),
        .i_error_chid (i_error_chid),
        .gen_valid    (gen_valid),
        .gen_chid     (gen_chid),
        .gen_type     (gen_type),
        .gen_ready    (gen_ready),
        .busy         (busy),
        .err_mask     (err_mask),
        .round_cnt    (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each handshake seen at negedge completes at the following posedge.
    always @(negedge clk) begin
        if (n_rst && gen_valid && gen_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 96'({gen_chid, gen_type}), 96'('1));
            end else begin
                check("frame", 96'({gen_chid, gen_type}), 96'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ch, input logic ty, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({CHID_W'(ch), ty});
        end
    endtask

    // Holds gen_ready high until exactly n more handshakes have completed.
    task automatic run_frames(input int n);
        int target;
        int budget;
        target    = hs_cnt + n;
        budget    = 0;
        gen_ready = 1'b1;
        while (hs_cnt < target && budget < 300) begin
            tick();
            budget++;
        end
        gen_ready = 1'b0;
        check("frames_done", 96'(hs_cnt), 96'(target));
    endtask

    task automatic do_reset();
        n_rst        = 1'b0;
        start        = 1'b0;
        gen_ready    = 1'b0;
        enable_chid  = '0;
        type_chid    = '0;
        i_error_chid = '0;
        tick();
        tick();
        check("rst_valid", 96'(gen_valid), 96'(0));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_chid_type", 96'({gen_chid, gen_type}), 96'(0));
        check("rst_err_mask", 96'(err_mask), 96'(0));
        check("rst_round_cnt", 96'(round_cnt), 96'(0));
        n_rst = 1'b1;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: two channels alternate, latency from start, gap and first wrap.
        do_reset();
        enable_chid[0] = 1'b1;
        enable_chid[2] = 1'b1;
        type_chid[2]   = 1'b1;
        start = 1'b1;
        tick();
        check("t1_lat_n1", 96'(gen_valid), 96'(0));
        tick();
        check("t1_lat_n2", 96'({gen_valid, busy, gen_chid}), 96'({2'b11, CHID_W'(0)}));
        push_exp(0, 1'b0, 4);
        push_exp(2, 1'b1, 4);
        push_exp(0, 1'b0, 4);
        run_frames(12);
        check("t1_gap", 96'(gen_valid), 96'(0));
        check("t1_round", 96'(round_cnt), 96'(1));
        tick();
        check("t1_next_grant", 96'({gen_valid, gen_chid, gen_type}), 96'({1'b1, CHID_W'(2), 1'b1}));

        // 2: pointer reaches the top channel and wraps back to channel 0.
        do_reset();
        enable_chid[0]  = 1'b1;
        enable_chid[79] = 1'b1;
        type_chid[79]   = 1'b1;
        start = 1'b1;
        push_exp(0, 1'b0, 4);
        push_exp(79, 1'b1, 4);
        run_frames(8);
        check("t2_round_before", 96'(round_cnt), 96'(0));
        tick();
        check("t2_round_after", 96'(round_cnt), 96'(1));
        check("t2_wrap_chid", 96'({gen_valid, gen_chid}), 96'({1'b1, CHID_W'(0)}));
        push_exp(0, 1'b0, 4);
        run_frames(4);

        // 3: stalled request stays stable; enable/type changes wait for next arbitration.
        do_reset();
        enable_chid[5] = 1'b1;
        type_chid[5]   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t3_stall", 96'({gen_valid, gen_chid, gen_type}), 96'({1'b1, CHID_W'(5), 1'b1}));
            if (i == 4) begin
                enable_chid = '0;
                enable_chid[6] = 1'b1;
                type_chid[5]   = 1'b0;
            end
            tick();
        end
        push_exp(5, 1'b1, 4);
        push_exp(6, 1'b0, 4);
        run_frames(8);
        check("t3_round0", 96'(round_cnt), 96'(0));
        tick();
        check("t3_round1", 96'(round_cnt), 96'(1));
        push_exp(6, 1'b0, 4);
        run_frames(4);
        tick();
        check("t3_round2", 96'(round_cnt), 96'(2));

        // 4: error on ch2 ends its burst early and masks it until start re-rises.
        do_reset();
        enable_chid[0] = 1'b1;
        enable_chid[2] = 1'b1;
        start = 1'b1;
        push_exp(0, 1'b0, 4);
        push_exp(2, 1'b0, 2);
        push_exp(0, 1'b0, 8);
        run_frames(5);
        i_error_chid[2] = 1'b1;
        tick();
        i_error_chid = '0;
        check("t4_err_set", 96'(err_mask), 96'(1) << 2);
        run_frames(9);
        check("t4_round", 96'(round_cnt), 96'(2));
        start = 1'b0;
        tick();
        tick();
        check("t4_err_held", 96'(err_mask), 96'(1) << 2);
        start = 1'b1;
        tick();
        check("t4_err_clear", 96'(err_mask), 96'(0));
        push_exp(2, 1'b0, 4);
        run_frames(4);

        // 5: start drops mid-burst while stalled; request held until accepted.
        do_reset();
        enable_chid[3] = 1'b1;
        start = 1'b1;
        push_exp(3, 1'b0, 3);
        run_frames(2);
        start = 1'b0;
        tick();
        tick();
        tick();
        check("t5_held", 96'({gen_valid, busy, gen_chid}), 96'({2'b11, CHID_W'(3)}));
        run_frames(1);
        check("t5_end", 96'({gen_valid, busy}), 96'(0));
        tick();
        tick();
        check("t5_idle", 96'({gen_valid, busy}), 96'(0));

        // 6: asynchronous reset in the middle of an issued request.
        do_reset();
        enable_chid[0] = 1'b1;
        enable_chid[1] = 1'b1;
        start = 1'b1;
        push_exp(0, 1'b0, 4);
        push_exp(1, 1'b0, 4);
        push_exp(0, 1'b0, 4);
        run_frames(12);
        i_error_chid[40] = 1'b1;
        tick();
        i_error_chid = '0;
        check("t6_pre_err", 96'(err_mask), 96'(1) << 40);
        check("t6_pre_round", 96'(round_cnt), 96'(1));
        check("t6_pre_issue", 96'({gen_valid, gen_chid}), 96'({1'b1, CHID_W'(1)}));
        #2;
        n_rst = 1'b0;
        #1;
        check("t6_rst_valid", 96'({gen_valid, busy}), 96'(0));
        check("t6_rst_err", 96'(err_mask), 96'(0));
        check("t6_rst_round", 96'(round_cnt), 96'(0));
        tick();
        n_rst = 1'b1;
        push_exp(0, 1'b0, 4);
        run_frames(4);

        check("queue_empty", 96'(exp_q.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
